// File: rtl/valve_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer_if
// Purpose  : Bundles the valve request/enable signals between the reservoir
//            level FSM (master) and the valve sequencer (slave).
// Revision : 1.0  initial release
// ============================================================================
interface valve_sequencer_if;
  logic       en;       // run enable, 0 = emergency stop
  logic [3:0] req;      // requested valves {dfr, fr3, fr2, fr1}
  logic [3:0] valve;    // driven valve enables, same mapping as req
  logic       busy;     // some valve differs from its request
  logic       opening;  // one-cycle pulse after each valve opening

  modport master (
    output en,
    output req,
    input  valve,
    input  busy,
    input  opening
  );

  modport slave (
    input  en,
    input  req,
    output valve,
    output busy,
    output opening
  );
endinterface
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer
// Purpose  : Converts the requested flow-valve pattern into real valve
//            enables. Openings are staggered (one per STAGGER cycles, lowest
//            index first) to limit supply inrush, every opened valve is held
//            for at least MIN_ON cycles, and en=0 drops all valves at once.
// Revision : 1.0  initial release
// ============================================================================
module valve_sequencer #(
  parameter int unsigned STAGGER = 4,  // cycles between openings, 1..255
  parameter int unsigned MIN_ON  = 8   // minimum open cycles, 1..255
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  valve_sequencer_if.slave bus
);

  // Stagger FSM encoding
  localparam logic [0:0] READY = 1'b0;  // an opening is allowed this edge
  localparam logic [0:0] HOLD  = 1'b1;  // stagger counter still running

  // Counter reload values, truncated to the 8-bit counter width
  localparam logic [7:0] STAGGER_LOAD = 8'(STAGGER - 1);
  localparam logic [7:0] MIN_ON_LOAD  = 8'(MIN_ON - 1);

  // With STAGGER=1 back-to-back openings are allowed and HOLD is never used
  localparam logic USE_HOLD = (STAGGER > 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0] stagger_state;
  logic [7:0] stagger_cnt;
  logic [7:0] on_timer [4];
  logic [3:0] valve_cur;
  logic       busy_cur;
  logic       opening_cur;

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  logic [3:0] pending;     // requested but not yet open
  logic [3:0] lowest_pend; // lowest-index pending valve, one-hot or zero
  logic [3:0] open_sel;    // valve opened on this edge (one-hot or zero)
  logic [3:0] close_sel;   // valves closed on this edge
  logic [3:0] valve_next;  // valve vector after this edge
  logic       open_any;

  // Pick the single valve allowed to open and every valve allowed to close
  always_comb begin
    pending     = bus.req & ~valve_cur;
    // Two's-complement trick isolates the lowest set bit (fr1 wins)
    lowest_pend = pending & (~pending + 4'd1);
    open_sel    = (stagger_state == READY) ? lowest_pend : 4'b0000;
    open_any    = |open_sel;

    close_sel   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      // A dropped request only closes once the minimum on-time has run out
      close_sel[i] = valve_cur[i] & ~bus.req[i] & (on_timer[i] == 8'd0);
    end

    // Emergency stop drops every valve regardless of its on-timer
    if (bus.en) begin
      valve_next = (valve_cur & ~close_sel) | open_sel;
    end else begin
      valve_next = 4'b0000;
    end
  end

  // --------------------------------------------------------------------------
  // Per-valve minimum on-time counters
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_on_timer
    // Load on opening, count down while open, saturate at zero
    always_ff @(posedge clk) begin
      if (!resetn) begin
        on_timer[gi] <= 8'd0;
      end else if (!bus.en) begin
        on_timer[gi] <= 8'd0;
      end else if (open_sel[gi]) begin
        on_timer[gi] <= MIN_ON_LOAD;
      end else if (valve_cur[gi] && (on_timer[gi] != 8'd0)) begin
        on_timer[gi] <= on_timer[gi] - 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stagger FSM: after an opening, block further openings for STAGGER-1 edges
  // --------------------------------------------------------------------------
  // Track the spacing between successive openings
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stagger_state <= READY;
      stagger_cnt   <= 8'd0;
    end else if (!bus.en) begin
      stagger_state <= READY;
      stagger_cnt   <= 8'd0;
    end else begin
      case (stagger_state)
        READY: begin
          if (open_any && USE_HOLD) begin
            stagger_cnt   <= STAGGER_LOAD;
            stagger_state <= HOLD;
          end
        end
        HOLD: begin
          // The edge that brings the counter to zero re-enables openings
          if (stagger_cnt > 8'd1) begin
            stagger_cnt <= stagger_cnt - 8'd1;
          end else begin
            stagger_cnt   <= 8'd0;
            stagger_state <= READY;
          end
        end
        default: begin
          stagger_cnt   <= 8'd0;
          stagger_state <= READY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  // Valve enables plus status flags derived from the post-edge valve vector
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valve_cur   <= 4'b0000;
      busy_cur    <= 1'b0;
      opening_cur <= 1'b0;
    end else begin
      valve_cur   <= valve_next;
      busy_cur    <= |(bus.req ^ valve_next);
      opening_cur <= bus.en & open_any;
    end
  end

  assign bus.valve   = valve_cur;
  assign bus.busy    = busy_cur;
  assign bus.opening = opening_cur;

endmodule
`default_nettype wire
